// File: rtl/dpram_arbiter.sv
// -----------------------------------------------------------------------------
// dpram_arbiter
//
// Round-robin arbiter that shares the two ports of a Dual_Port_RAM between
// NREQ requesters. Each cycle it can grant two requests, one per RAM port. It
// drives the enable, read-enable, address and write data of each port. Read
// data returns to the owning requester in the cycle after the grant.
//
// Parameters
//   WIDTH  data width (matches the RAM)
//   DEPTH  RAM depth; ADDR = $clog2(DEPTH)
//   NREQ   number of requesters (2..8)
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req, we               per-requester request and transfer type (1 = write)
//   addr, wdata           flattened per-requester address and write data
//   gnt                   combinational grant, at most two bits set
//   rvalid, rdata         per-requester read return (cycle after the grant)
//   en1/en2               RAM port enables
//   rd_en1/rd_en2         RAM port read enables (1 = read, 0 = write)
//   addr1/addr2           RAM port addresses
//   data_in1/data_in2     RAM port write data
//   data_out1/data_out2   RAM port read data (valid the cycle after the read)
// -----------------------------------------------------------------------------
module dpram_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int NREQ  = 4,
    localparam int ADDR = $clog2(DEPTH),
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         we,
    input  logic [NREQ*ADDR-1:0]    addr,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rvalid,
    output logic [NREQ*WIDTH-1:0]   rdata,
    output logic                    en1,
    output logic                    en2,
    output logic                    rd_en1,
    output logic                    rd_en2,
    output logic [ADDR-1:0]         addr1,
    output logic [ADDR-1:0]         addr2,
    output logic [WIDTH-1:0]        data_in1,
    output logic [WIDTH-1:0]        data_in2,
    input  logic [WIDTH-1:0]        data_out1,
    input  logic [WIDTH-1:0]        data_out2
);

    // Round-robin pointer
    logic [PW-1:0]          ptr_q, ptr_d;

    // Read tags: one per RAM port, remembering which requester owns the read
    logic                   tag1_vld_q, tag1_vld_d;
    logic                   tag2_vld_q, tag2_vld_d;
    logic [PW-1:0]          tag1_idx_q, tag1_idx_d;
    logic [PW-1:0]          tag2_idx_q, tag2_idx_d;

    // Read data holding register
    logic [NREQ*WIDTH-1:0]  rdata_q, rdata_d;

    // Arbitration results
    logic                   p1_vld;
    logic [PW-1:0]          p1_idx;
    int                     p1_off;
    logic                   p2c_vld;
    logic [PW-1:0]          p2_idx;
    logic                   conflict;
    logic                   g1, g2;
    logic [ADDR-1:0]        addr_p1, addr_p2;

    // -------------------------------------------------------------------------
    // Candidate search. Port 1 takes the first request at or after ptr. Port 2
    // takes the next one after it, stopping before the scan returns to ptr,
    // which keeps it at a strictly larger offset from ptr.
    // -------------------------------------------------------------------------
    always_comb begin
        int j;
        p1_vld  = 1'b0;
        p1_idx  = '0;
        p1_off  = 0;
        p2c_vld = 1'b0;
        p2_idx  = '0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_q) + k) % NREQ;
            if (!p1_vld && req[j]) begin
                p1_vld = 1'b1;
                p1_idx = PW'(j);
                p1_off = k;
            end
        end
        for (int k = 1; k < NREQ; k++) begin
            j = (int'(ptr_q) + k) % NREQ;
            if (p1_vld && !p2c_vld && (k > p1_off) && req[j]) begin
                p2c_vld = 1'b1;
                p2_idx  = PW'(j);
            end
        end
    end

    assign addr_p1 = addr[p1_idx*ADDR +: ADDR];
    assign addr_p2 = addr[p2_idx*ADDR +: ADDR];

    // A same-address pair involving a write is serialized. Port 2 backs off
    // so that port 1, which holds the older claim, completes first.
    assign conflict = p2c_vld && (addr_p1 == addr_p2) && (we[p1_idx] || we[p2_idx]);

    // Everything visible to the RAM or the clients is forced idle in reset.
    assign g1 = rst_n && p1_vld;
    assign g2 = rst_n && p2c_vld && !conflict;

    // -------------------------------------------------------------------------
    // Grant and RAM port drive
    // -------------------------------------------------------------------------
    always_comb begin
        gnt = '0;
        if (g1) gnt[p1_idx] = 1'b1;
        if (g2) gnt[p2_idx] = 1'b1;
    end

    assign en1      = g1;
    assign rd_en1   = g1 && !we[p1_idx];
    assign addr1    = g1 ? addr_p1 : '0;
    assign data_in1 = g1 ? wdata[p1_idx*WIDTH +: WIDTH] : '0;

    assign en2      = g2;
    assign rd_en2   = g2 && !we[p2_idx];
    assign addr2    = g2 ? addr_p2 : '0;
    assign data_in2 = g2 ? wdata[p2_idx*WIDTH +: WIDTH] : '0;

    // -------------------------------------------------------------------------
    // Pointer and tag next state
    // -------------------------------------------------------------------------
    always_comb begin
        ptr_d = ptr_q;
        if (g2) begin
            ptr_d = PW'((int'(p2_idx) + 1) % NREQ);
        end else if (g1) begin
            ptr_d = PW'((int'(p1_idx) + 1) % NREQ);
        end
        tag1_vld_d = g1 && !we[p1_idx];
        tag1_idx_d = p1_idx;
        tag2_vld_d = g2 && !we[p2_idx];
        tag2_idx_d = p2_idx;
    end

    // -------------------------------------------------------------------------
    // Read return. The RAM output register holds the data in the cycle after
    // the grant. It is steered to its owner directly and also captured so
    // rdata holds the value until the next return to that requester. The two
    // tags can never name the same requester, so their order does not matter.
    // -------------------------------------------------------------------------
    always_comb begin
        rvalid  = '0;
        rdata_d = rdata_q;
        if (tag1_vld_q) begin
            rvalid[tag1_idx_q]                  = 1'b1;
            rdata_d[tag1_idx_q*WIDTH +: WIDTH]  = data_out1;
        end
        if (tag2_vld_q) begin
            rvalid[tag2_idx_q]                  = 1'b1;
            rdata_d[tag2_idx_q*WIDTH +: WIDTH]  = data_out2;
        end
    end

    assign rdata = rdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            tag1_vld_q <= 1'b0;
            tag2_vld_q <= 1'b0;
            tag1_idx_q <= '0;
            tag2_idx_q <= '0;
            rdata_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            tag1_vld_q <= tag1_vld_d;
            tag2_vld_q <= tag2_vld_d;
            tag1_idx_q <= tag1_idx_d;
            tag2_idx_q <= tag2_idx_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dpram_arbiter
//
// Directed bench for dpram_arbiter (WIDTH=8, DEPTH=16, NREQ=4) with a
// behavioural dual-port RAM model attached to the RAM-side ports. Inputs are
// driven on the falling edge and outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_dpram_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int NREQ  = 4;
    localparam int ADDR  = 4;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       we;
    logic [NREQ*ADDR-1:0]  addr;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rvalid;
    logic [NREQ*WIDTH-1:0] rdata;
    logic                  en1, en2, rd_en1, rd_en2;
    logic [ADDR-1:0]       addr1, addr2;
    logic [WIDTH-1:0]      data_in1, data_in2;
    logic [WIDTH-1:0]      data_out1, data_out2;

    int n_vec = 0;
    int n_bad = 0;

    dpram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .en1(en1), .en2(en2), .rd_en1(rd_en1), .rd_en2(rd_en2),
        .addr1(addr1), .addr2(addr2),
        .data_in1(data_in1), .data_in2(data_in2),
        .data_out1(data_out1), .data_out2(data_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port RAM with registered read data
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (en1) begin
            if (rd_en1) data_out1 <= mem[addr1];
            else        mem[addr1] <= data_in1;
        end
        if (en2) begin
            if (rd_en2) data_out2 <= mem[addr2];
            else        mem[addr2] <= data_in2;
        end
    end

    task automatic idle();
        req = '0; we = '0; addr = '0; wdata = '0;
    endtask

    task automatic set_req(input int i, input logic w, input logic [3:0] a, input logic [7:0] d);
        req[i] = 1'b1;
        we[i]  = w;
        addr[i*ADDR +: ADDR]   = a;
        wdata[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        req = 4'b1111;
        #1;
        n_vec++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        n_vec++; if ({en1, en2, rd_en1, rd_en2} !== 4'b0000) begin n_bad++; $display("FAIL rst_en: got %b want 0000", {en1, en2, rd_en1, rd_en2}); end
        n_vec++; if (rvalid !== 4'b0000) begin n_bad++; $display("FAIL rst_rvalid: got %b want 0000", rvalid); end
        n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        n_vec++; if ({addr1, addr2, data_in1, data_in2} !== 24'h0) begin n_bad++; $display("FAIL rst_bus: got %h want 0", {addr1, addr2, data_in1, data_in2}); end
        @(negedge clk);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (gnt !== 4'b0000 || rvalid !== 4'b0000) begin n_bad++; $display("FAIL rst_idle: got gnt=%b rvalid=%b want 0000", gnt, rvalid); end
    endtask

    task automatic test_dual_write_read();
        @(negedge clk);
        idle();
        set_req(0, 1'b1, 4'd0, 8'hAA);
        set_req(1, 1'b1, 4'd1, 8'h12);
        #1;
        n_vec++; if (gnt !== 4'b0011) begin n_bad++; $display("FAIL dw_gnt: got %b want 0011", gnt); end
        n_vec++; if ({en1, en2, rd_en1, rd_en2} !== 4'b1100) begin n_bad++; $display("FAIL dw_en: got %b want 1100", {en1, en2, rd_en1, rd_en2}); end
        n_vec++; if (addr1 !== 4'd0 || addr2 !== 4'd1) begin n_bad++; $display("FAIL dw_addr: got %0d/%0d want 0/1", addr1, addr2); end
        n_vec++; if (data_in1 !== 8'hAA || data_in2 !== 8'h12) begin n_bad++; $display("FAIL dw_data: got %h/%h want aa/12", data_in1, data_in2); end
        @(negedge clk);
        idle();
        set_req(0, 1'b0, 4'd0, 8'h00);
        set_req(1, 1'b0, 4'd1, 8'h00);
        #1;
        n_vec++; if (gnt !== 4'b0011) begin n_bad++; $display("FAIL dr_gnt: got %b want 0011", gnt); end
        n_vec++; if ({en1, en2, rd_en1, rd_en2} !== 4'b1111) begin n_bad++; $display("FAIL dr_en: got %b want 1111", {en1, en2, rd_en1, rd_en2}); end
        n_vec++; if (rvalid !== 4'b0000) begin n_bad++; $display("FAIL dw_no_rvalid: got %b want 0000", rvalid); end
        @(negedge clk);
        idle();
        #1;
        n_vec++; if (rvalid !== 4'b0011) begin n_bad++; $display("FAIL dr_rvalid: got %b want 0011", rvalid); end
        n_vec++; if (rdata[7:0] !== 8'hAA || rdata[15:8] !== 8'h12) begin n_bad++; $display("FAIL dr_rdata: got %h/%h want aa/12", rdata[7:0], rdata[15:8]); end
        @(negedge clk);
        #1;
        n_vec++; if (rvalid !== 4'b0000 || rdata[7:0] !== 8'hAA) begin n_bad++; $display("FAIL dr_hold: got rvalid=%b rdata0=%h want 0000/aa", rvalid, rdata[7:0]); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [5];
        logic [3:0] exp_rv  [5];
        exp_gnt[0] = 4'b0011; exp_rv[0] = 4'b0000;
        exp_gnt[1] = 4'b1100; exp_rv[1] = 4'b0011;
        exp_gnt[2] = 4'b0011; exp_rv[2] = 4'b1100;
        exp_gnt[3] = 4'b1100; exp_rv[3] = 4'b0011;
        exp_gnt[4] = 4'b0000; exp_rv[4] = 4'b1100;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            idle();
            if (c < 4) begin
                set_req(0, 1'b0, 4'd0, 8'h00);
                set_req(1, 1'b0, 4'd1, 8'h00);
                set_req(2, 1'b0, 4'd0, 8'h00);
                set_req(3, 1'b0, 4'd1, 8'h00);
            end
            #1;
            n_vec++; if (gnt !== exp_gnt[c]) begin n_bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, gnt, exp_gnt[c]); end
            n_vec++; if (rvalid !== exp_rv[c]) begin n_bad++; $display("FAIL rr_rvalid[%0d]: got %b want %b", c, rvalid, exp_rv[c]); end
            if (c == 2) begin
                n_vec++; if (rdata[23:16] !== 8'hAA || rdata[31:24] !== 8'h12) begin n_bad++; $display("FAIL rr_rdata23: got %h/%h want aa/12", rdata[23:16], rdata[31:24]); end
            end
        end
    endtask

    task automatic test_addr_conflict();
        do_reset();
        @(negedge clk);
        idle();
        set_req(1, 1'b1, 4'd2, 8'h33);
        #1;
        n_vec++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL ac_pre_gnt: got %b want 0010", gnt); end
        @(negedge clk);
        idle();
        set_req(2, 1'b1, 4'd5, 8'h5A);
        set_req(3, 1'b0, 4'd5, 8'h00);
        #1;
        n_vec++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL ac_gnt_n: got %b want 0100", gnt); end
        n_vec++; if ({en1, rd_en1, addr1} !== {1'b1, 1'b0, 4'd5}) begin n_bad++; $display("FAIL ac_p1_n: got en=%b rd=%b a=%0d want 1/0/5", en1, rd_en1, addr1); end
        n_vec++; if ({en2, rd_en2, addr2, data_in2} !== 14'h0) begin n_bad++; $display("FAIL ac_p2_idle: got %h want 0", {en2, rd_en2, addr2, data_in2}); end
        @(negedge clk);
        idle();
        set_req(3, 1'b0, 4'd5, 8'h00);
        #1;
        n_vec++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL ac_gnt_n1: got %b want 1000", gnt); end
        n_vec++; if ({en1, rd_en1, addr1, en2} !== {1'b1, 1'b1, 4'd5, 1'b0}) begin n_bad++; $display("FAIL ac_p1_n1: got en=%b rd=%b a=%0d en2=%b want 1/1/5/0", en1, rd_en1, addr1, en2); end
        @(negedge clk);
        idle();
        set_req(0, 1'b0, 4'd5, 8'h00);
        set_req(1, 1'b0, 4'd5, 8'h00);
        #1;
        n_vec++; if (rvalid !== 4'b1000 || rdata[31:24] !== 8'h5A) begin n_bad++; $display("FAIL ac_ret: got rvalid=%b rdata3=%h want 1000/5a", rvalid, rdata[31:24]); end
        n_vec++; if (gnt !== 4'b0011) begin n_bad++; $display("FAIL rr_same_addr_gnt: got %b want 0011", gnt); end
        @(negedge clk);
        idle();
        #1;
        n_vec++; if (rvalid !== 4'b0011 || rdata[15:0] !== 16'h5A5A) begin n_bad++; $display("FAIL rr_same_addr_ret: got rvalid=%b rdata10=%h want 0011/5a5a", rvalid, rdata[15:0]); end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        idle();
        set_req(3, 1'b1, 4'd7, 8'h14);
        #1;
        n_vec++; if (gnt !== 4'b1000 || en1 !== 1'b1 || en2 !== 1'b0 || data_in1 !== 8'h14) begin n_bad++; $display("FAIL sg_wr: got gnt=%b en1=%b en2=%b d=%h want 1000/1/0/14", gnt, en1, en2, data_in1); end
        @(negedge clk);
        set_req(3, 1'b0, 4'd7, 8'h00);
        #1;
        n_vec++; if (gnt !== 4'b1000 || rd_en1 !== 1'b1 || addr1 !== 4'd7 || en2 !== 1'b0) begin n_bad++; $display("FAIL sg_rd: got gnt=%b rd=%b a=%0d en2=%b want 1000/1/7/0", gnt, rd_en1, addr1, en2); end
        @(negedge clk);
        #1;
        n_vec++; if (gnt !== 4'b1000 || rvalid !== 4'b1000 || rdata[31:24] !== 8'h14) begin n_bad++; $display("FAIL sg_ret: got gnt=%b rvalid=%b rdata3=%h want 1000/1000/14", gnt, rvalid, rdata[31:24]); end
        @(negedge clk);
        idle();
        set_req(0, 1'b0, 4'd0, 8'h00);
        set_req(3, 1'b0, 4'd7, 8'h00);
        #1;
        n_vec++; if (gnt !== 4'b1001 || addr1 !== 4'd0 || addr2 !== 4'd7) begin n_bad++; $display("FAIL sg_ptr0: got gnt=%b a1=%0d a2=%0d want 1001/0/7", gnt, addr1, addr2); end
        @(negedge clk);
        idle();
        #1;
        n_vec++; if (rvalid !== 4'b1001 || rdata[7:0] !== 8'hAA || rdata[31:24] !== 8'h14) begin n_bad++; $display("FAIL sg_dual_ret: got rvalid=%b r0=%h r3=%h want 1001/aa/14", rvalid, rdata[7:0], rdata[31:24]); end
    endtask

    task automatic test_sparse_wrap();
        do_reset();
        @(negedge clk);
        idle();
        set_req(2, 1'b0, 4'd2, 8'h00);
        #1;
        n_vec++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL sw_pre_gnt: got %b want 0100", gnt); end
        @(negedge clk);
        idle();
        set_req(3, 1'b0, 4'd7, 8'h00);
        set_req(0, 1'b0, 4'd0, 8'h00);
        #1;
        n_vec++; if (gnt !== 4'b1001 || addr1 !== 4'd7 || addr2 !== 4'd0) begin n_bad++; $display("FAIL sw_gnt: got gnt=%b a1=%0d a2=%0d want 1001/7/0", gnt, addr1, addr2); end
        n_vec++; if (rvalid !== 4'b0100 || rdata[23:16] !== 8'h33) begin n_bad++; $display("FAIL sw_pre_ret: got rvalid=%b r2=%h want 0100/33", rvalid, rdata[23:16]); end
        @(negedge clk);
        idle();
        set_req(0, 1'b0, 4'd0, 8'h00);
        set_req(1, 1'b0, 4'd1, 8'h00);
        #1;
        n_vec++; if (gnt !== 4'b0011 || addr1 !== 4'd1 || addr2 !== 4'd0) begin n_bad++; $display("FAIL sw_ptr1: got gnt=%b a1=%0d a2=%0d want 0011/1/0", gnt, addr1, addr2); end
        n_vec++; if (rvalid !== 4'b1001 || rdata[31:24] !== 8'h14 || rdata[7:0] !== 8'hAA) begin n_bad++; $display("FAIL sw_ret: got rvalid=%b r3=%h r0=%h want 1001/14/aa", rvalid, rdata[31:24], rdata[7:0]); end
        @(negedge clk);
        idle();
        #1;
        n_vec++; if (rvalid !== 4'b0011 || rdata[15:8] !== 8'h12) begin n_bad++; $display("FAIL sw_ret2: got rvalid=%b r1=%h want 0011/12", rvalid, rdata[15:8]); end
    endtask

    task automatic test_reset_pending();
        @(negedge clk);
        idle();
        set_req(0, 1'b0, 4'd0, 8'h00);
        #1;
        n_vec++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rp_gnt: got %b want 0001", gnt); end
        @(posedge clk);
        #1;
        n_vec++; if (rvalid !== 4'b0001) begin n_bad++; $display("FAIL rp_pending: got %b want 0001", rvalid); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (rvalid !== 4'b0000 || rdata !== 32'h0) begin n_bad++; $display("FAIL rp_clear: got rvalid=%b rdata=%h want 0000/0", rvalid, rdata); end
        n_vec++; if (gnt !== 4'b0000 || {en1, rd_en1, addr1, data_in1} !== 14'h0) begin n_bad++; $display("FAIL rp_force: got gnt=%b port1=%h want 0000/0", gnt, {en1, rd_en1, addr1, data_in1}); end
        @(negedge clk);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            n_vec++; if (rvalid !== 4'b0000) begin n_bad++; $display("FAIL rp_no_rvalid[%0d]: got %b want 0000", c, rvalid); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_dual_write_read();
        test_round_robin();
        test_addr_conflict();
        test_single();
        test_sparse_wrap();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
